data_bus_fabric: RTL
====================

// Module: data_bus_fabric
// PURPOSE
//  Parametrised data-side interconnect between the core LSU port (req/gnt/rvalid) and
//  NUM_SLV slaves: slot 0 = data memory, slots 1..NUM_SLV-1 = peripherals.
//  Successor to the fixed single-cycle decoder. Adds variable-latency slaves through a
//  per-slave rvalid handshake, an error response for unmapped addresses, and an optional
//  response timeout. One outstanding transaction at a time.
// PARAMETERS
//  NUM_SLV  9    slave slots incl. data memory (2..1+2**SEL_W)
//  MEM_BIT  16   addr bit: 0 -> data memory (slot 0), 1 -> peripheral region
//  SEL_LSB  13   LSB of peripheral select field in data_addr_i
//  SEL_W    3    width of peripheral select field
//  TIMEOUT  255  cycles in WAIT before abort (BUS_TIMEOUT_EN only), 1..65535
// PORTS
//  clk_i          in   1            clock, rising edge
//  rst_ni         in   1            asynchronous reset, active low
//  data_req_i     in   1            core request
//  data_we_i      in   1            1 = write
//  data_be_i      in   4            byte enables
//  data_addr_i    in   32           byte address
//  data_wdata_i   in   32           write data
//  data_gnt_o     out  1            request accepted this cycle
//  data_rvalid_o  out  1            one-cycle response pulse
//  data_err_o     out  1            response is an error (valid with rvalid)
//  data_rdata_o   out  32           read data (valid with rvalid)
//  slv_req_o      out  NUM_SLV      one-hot one-cycle request strobe per slot
//  slv_we_o       out  1            latched write enable, shared
//  slv_be_o       out  4            latched byte enables, shared
//  slv_addr_o     out  32           latched address, shared
//  slv_wdata_o    out  32           latched write data, shared
//  slv_rvalid_i   in   NUM_SLV      per-slot completion pulse
//  slv_rdata_i    in   32*NUM_SLV   per-slot read data; slot k at [32k+:32]
// BEHAVIOUR
//  Reset: every output 0; state IDLE; latched request fields 0.
//  Decode: slot = addr[MEM_BIT] ? 1 + addr[SEL_LSB+:SEL_W] : 0.
//    Slot >= NUM_SLV means unmapped.
//  FSM IDLE/ISSUE/WAIT/RESP:
//  - IDLE: data_gnt_o = data_req_i (combinational). gnt is 0 in every other state.
//    On accept at cycle T: latch we/be/addr/wdata and slot.
//    Next state is ISSUE, or RESP with err=1, rdata=0 if unmapped.
//  - ISSUE (T+1): slv_req_o[slot]=1 for exactly this cycle; -> WAIT.
//  - WAIT: wait for slv_rvalid_i[slot]. rvalid on non-selected slots is ignored.
//    On rvalid: capture slv_rdata_i[slot] for reads (0 for writes); -> RESP.
//    slv_rvalid_i asserted during ISSUE is also accepted (completion in ISSUE -> RESP).
//  - RESP: data_rvalid_o=1 one cycle, data_err_o per outcome; -> IDLE.
//  Min latency: gnt at T, rvalid at T+3 for a slave answering the cycle after its req.
//  Sustained throughput: one transaction per 4 cycles.
//  data_rdata_o holds its last response value between pulses.
//    data_err_o is 0 whenever rvalid is 0.
//  slv_* shared fields hold their latched values until the next accept.
//  Reset asserted mid-transaction: slv_req_o drops immediately, no response issued,
//    state IDLE.
//  A late slave rvalid arriving in IDLE/RESP is ignored.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined:
//  - 16-bit counter cleared on entry to WAIT, incremented each WAIT cycle.
//  - If it reaches TIMEOUT with no rvalid: -> RESP with err=1, rdata=32'hDEADBEEF.
//  - A slave rvalid in the same cycle the count reaches TIMEOUT wins (normal response).
//  BUS_TIMEOUT_EN undefined:
//  - No counter; WAIT lasts until rvalid, indefinitely.
//  - data_err_o is set only for unmapped addresses.
// TESTING
//  1 Read 0x0000_0010, slot0 rvalid 1 cycle after req, rdata 0x1234_5678 ->
//    gnt T, slv_req_o=9'h001 at T+1, rvalid T+3, rdata 0x1234_5678, err 0.
//  2 Write 0x0001_A004 (slot 6), wdata 0xCAFE_0001, be 4'b0011, slave waits 5 cycles ->
//    slv_req_o=9'h040 once; slv_wdata/be held; rvalid at T+7; rdata 0; err 0.
//  3 NUM_SLV=4, read 0x0001_8000 (slot 5, unmapped) ->
//    no slv_req_o; rvalid at T+1, err 1, rdata 0.
//  4 req held high through a transaction ->
//    gnt 0 in ISSUE/WAIT/RESP; second accept no earlier than the IDLE cycle after RESP.
//  5 BUS_TIMEOUT_EN, TIMEOUT=8, slot 2 never answers ->
//    rvalid, err 1, rdata 32'hDEADBEEF; late slot-2 rvalid afterwards ignored.
//  6 rst_ni low during WAIT ->
//    all outputs 0 asynchronously; after release, a fresh read completes normally.

Source files
------------

// File: rtl/data_bus_fabric_if.sv
// Data-side bus bundle: core LSU port (req/gnt/rvalid) plus the shared slave-side fields.
// The fabric uses the slave modport; the environment (core + slaves) uses master.
interface data_bus_fabric_if #(
    parameter int NUM_SLV = 9
);
    logic                     data_req_i;
    logic                     data_we_i;
    logic [3:0]               data_be_i;
    logic [31:0]              data_addr_i;
    logic [31:0]              data_wdata_i;
    logic                     data_gnt_o;
    logic                     data_rvalid_o;
    logic                     data_err_o;
    logic [31:0]              data_rdata_o;
    logic [NUM_SLV-1:0]       slv_req_o;
    logic                     slv_we_o;
    logic [3:0]               slv_be_o;
    logic [31:0]              slv_addr_o;
    logic [31:0]              slv_wdata_o;
    logic [NUM_SLV-1:0]       slv_rvalid_i;
    logic [32*NUM_SLV-1:0]    slv_rdata_i;

    modport slave (
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
        output slv_req_o, slv_we_o, slv_be_o, slv_addr_o, slv_wdata_o,
        input  slv_rvalid_i, slv_rdata_i
    );

    modport master (
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
        input  slv_req_o, slv_we_o, slv_be_o, slv_addr_o, slv_wdata_o,
        output slv_rvalid_i, slv_rdata_i
    );
endinterface

// File: rtl/data_bus_fabric.sv
// Data-side interconnect: LSU port to NUM_SLV variable-latency slaves, one outstanding transaction.
// Optional response timeout enabled by defining BUS_TIMEOUT_EN.
module data_bus_fabric #(
    parameter int NUM_SLV = 9,
    parameter int MEM_BIT = 16,
    parameter int SEL_LSB = 13,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    data_bus_fabric_if.slave   bus
);
    localparam int SLOT_W = SEL_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    if ((NUM_SLV < 2) || (NUM_SLV > 1 + 2**SEL_W) || (TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_param_check
        $error("data_bus_fabric: parameter out of range");
    end

    logic [1:0]         r_state;
    logic [NUM_SLV-1:0] r_sel;
    logic               r_we;
    logic [3:0]         r_be;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic               r_err;

    logic [SLOT_W-1:0]  w_slot;
    logic [NUM_SLV-1:0] w_dec;
    logic               w_unmapped;
    logic               w_accept;
    logic               w_done;
    logic               w_expire;
    logic [31:0]        w_slv_rdata;

    assign w_slot = bus.data_addr_i[MEM_BIT]
                  ? SLOT_W'(1) + SLOT_W'(bus.data_addr_i[SEL_LSB +: SEL_W])
                  : '0;

    // One-hot decode; a slot beyond NUM_SLV matches nothing, which is what marks it unmapped.
    always_comb begin
        w_dec = '0;
        for (int unsigned k = 0; k < NUM_SLV; k++) begin
            w_dec[k] = (32'(w_slot) == k);
        end
    end

    always_comb begin
        w_slv_rdata = '0;
        for (int unsigned k = 0; k < NUM_SLV; k++) begin
            if (r_sel[k]) begin
                w_slv_rdata = w_slv_rdata | bus.slv_rdata_i[32*k +: 32];
            end
        end
    end

    assign w_unmapped = ~|w_dec;
    assign w_accept   = (r_state == S_IDLE) && bus.data_req_i;
    assign w_done     = |(bus.slv_rvalid_i & r_sel);

`ifdef BUS_TIMEOUT_EN
    logic [15:0] r_cnt;

    // Expire on the WAIT cycle whose increment brings the count to TIMEOUT.
    assign w_expire = (r_state == S_WAIT) && (r_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= bus.data_we_i;
                        r_be    <= bus.data_be_i;
                        r_addr  <= bus.data_addr_i;
                        r_wdata <= bus.data_wdata_i;
                        r_sel   <= w_dec;
                        if (w_unmapped) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                            r_state <= S_RESP;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (w_done) begin
                        r_rdata <= r_we ? '0 : w_slv_rdata;
                        r_err   <= 1'b0;
                        r_state <= S_RESP;
                    end else if (w_expire) begin
                        r_rdata <= 32'hDEADBEEF;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Grant is combinational from the request; gating with reset keeps it low while reset is held.
    assign bus.data_gnt_o    = rst_ni && w_accept;
    assign bus.data_rvalid_o = (r_state == S_RESP);
    assign bus.data_err_o    = (r_state == S_RESP) && r_err;
    assign bus.data_rdata_o  = r_rdata;
    assign bus.slv_req_o     = (r_state == S_ISSUE) ? r_sel : '0;
    assign bus.slv_we_o      = r_we;
    assign bus.slv_be_o      = r_be;
    assign bus.slv_addr_o    = r_addr;
    assign bus.slv_wdata_o   = r_wdata;
endmodule
